// File: rtl/debug_arb_pkg.sv
// Shared types and constants for the debug character sink arbiter.
package debug_arb_pkg;

   typedef enum logic {IDLE, STREAM} state_e;

   localparam logic [23:0] DBG_CHAR_ADDR = 24'h000000;
   localparam logic [7:0]  TERM_NUL      = 8'h00;
   localparam logic [7:0]  TERM_LF       = 8'h0A;

   function automatic logic is_term(input logic [7:0] b);
      return (b == TERM_NUL) || (b == TERM_LF);
   endfunction

endpackage

// File: rtl/debug_line_fifo.sv
// Per-requester byte FIFO that also tracks how many complete lines it holds.
module debug_line_fifo
   import debug_arb_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  logic [7:0]    push_data_i,
   input  logic          pop_i,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          has_line_o,
   output logic [7:0]    head_o
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, term_cnt_q;
   logic          push_term, pop_term;

   assign head_o     = mem_q[rd_ptr_q];
   assign count_o    = count_q;
   assign full_o     = (count_q == CW'(DEPTH));
   assign has_line_o = (term_cnt_q != '0);
   assign push_term  = push_i && is_term(push_data_i);
   assign pop_term   = pop_i && is_term(head_o);

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         term_cnt_q <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         case ({push_term, pop_term})
            2'b10:   term_cnt_q <= term_cnt_q + CW'(1);
            2'b01:   term_cnt_q <= term_cnt_q - CW'(1);
            default: term_cnt_q <= term_cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/debug_arbiter.sv
// Round-robin arbiter streaming whole buffered lines from NREQ requesters to one debug sink.
module debug_arbiter
   import debug_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int DEPTH = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [NREQ-1:0]   req_valid_i,
   input  logic [NREQ*8-1:0] req_data_i,
   output logic [NREQ-1:0]   req_ready_o,
   output logic              dbg_en_o,
   output logic              dbg_we_o,
   output logic [23:0]       dbg_addr_o,
   output logic [31:0]       dbg_data_o,
   output logic              busy_o
);

   localparam int GW = $clog2(NREQ);
   localparam int CW = $clog2(DEPTH + 1);

   logic [NREQ-1:0] full, has_line, cand, push, pop;
   logic [CW-1:0]   count [NREQ];
   logic [7:0]      head  [NREQ];

   state_e        state_q, state_d;
   logic [GW-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d;
   logic          line_mode_q, line_mode_d;
   logic [CW-1:0] pop_cnt_q, pop_cnt_d;
   logic          vld_p0, vld_p1;
   logic [7:0]    byte_p0, byte_p1;
   logic          found;
   int            idx;

   // Ready is held low throughout reset so nothing is accepted into cleared FIFOs.
   assign req_ready_o = rst_ni ? ~full : '0;
   assign push        = req_valid_i & req_ready_o;

   for (genvar i = 0; i < NREQ; i++) begin : g_fifo
      debug_line_fifo #(.DEPTH(DEPTH)) u_fifo (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .push_i      (push[i]),
         .push_data_i (req_data_i[8*i +: 8]),
         .pop_i       (pop[i]),
         .count_o     (count[i]),
         .full_o      (full[i]),
         .has_line_o  (has_line[i]),
         .head_o      (head[i])
      );
      assign cand[i] = has_line[i] || (count[i] == CW'(DEPTH));
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      line_mode_d = line_mode_q;
      pop_cnt_d   = pop_cnt_q;
      rr_ptr_d    = rr_ptr_q;
      pop         = '0;
      vld_p0      = 1'b0;
      byte_p0     = head[grant_q];
      found       = 1'b0;
      idx         = 0;
      case (state_q)
         IDLE: begin
            for (int k = 0; k < NREQ; k++) begin
               idx = int'(rr_ptr_q) + k;
               if (idx >= NREQ) idx = idx - NREQ;
               if (!found && cand[idx]) begin
                  found       = 1'b1;
                  grant_d     = GW'(idx);
                  line_mode_d = has_line[idx];
               end
            end
            if (found) begin
               state_d   = STREAM;
               pop_cnt_d = '0;
            end
         end
         STREAM: begin
            pop[grant_q] = 1'b1;
            vld_p0       = 1'b1;
            pop_cnt_d    = pop_cnt_q + CW'(1);
            if (line_mode_q ? is_term(byte_p0) : (pop_cnt_q == CW'(DEPTH - 1))) begin
               state_d  = IDLE;
               rr_ptr_d = (int'(grant_q) == NREQ - 1) ? '0 : grant_q + GW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // p0 -> p1: popped byte is registered onto the sink port
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         line_mode_q <= 1'b0;
         pop_cnt_q   <= '0;
         rr_ptr_q    <= '0;
         vld_p1      <= 1'b0;
         byte_p1     <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         line_mode_q <= line_mode_d;
         pop_cnt_q   <= pop_cnt_d;
         rr_ptr_q    <= rr_ptr_d;
         vld_p1      <= vld_p0;
         if (vld_p0) byte_p1 <= byte_p0;
      end
   end

   assign dbg_en_o   = vld_p1;
   assign dbg_we_o   = vld_p1;
   assign dbg_addr_o = DBG_CHAR_ADDR;
   assign dbg_data_o = {24'h0, byte_p1};
   assign busy_o     = (state_q == STREAM);

endmodule
